// File: rtl/cpu7_excp_redirect_pkg.sv
// Shared types and constants for the exception/ertn fetch-redirect unit.
package cpu7_excp_redirect_pkg;

  localparam int GRLEN = 32;

  // Encoding 2'b11 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_DRAIN = 2'b10
  } redir_state_t;

  // Fetch targets are word aligned, so the two low bits are dropped.
  function automatic logic [GRLEN-1:0] align_target(input logic [GRLEN-1:0] addr);
    return {addr[GRLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/cpu7_excp_redirect_if.sv
// Bundle of the CSR/ECL inputs and the IFU redirect handshake.
// master: the redirect unit; slave: its environment (CSR, ECL, IFU).
interface cpu7_excp_redirect_if;
  import cpu7_excp_redirect_pkg::*;

  logic             ecl_csr_ale_e;
  logic             ecl_csr_ertn_e;
  logic [GRLEN-1:0] csr_eentry;
  logic [GRLEN-1:0] csr_era;
  logic             ifu_exu_redirect_ack;
  logic             exu_ifu_redirect_vld;
  logic [GRLEN-1:0] exu_ifu_redirect_pc;
  logic             exu_ifu_redirect_ertn;
  logic             exu_flush;
  logic             exu_redirect_busy;

  modport master (
    input  ecl_csr_ale_e,
    input  ecl_csr_ertn_e,
    input  csr_eentry,
    input  csr_era,
    input  ifu_exu_redirect_ack,
    output exu_ifu_redirect_vld,
    output exu_ifu_redirect_pc,
    output exu_ifu_redirect_ertn,
    output exu_flush,
    output exu_redirect_busy
  );

  modport slave (
    output ecl_csr_ale_e,
    output ecl_csr_ertn_e,
    output csr_eentry,
    output csr_era,
    output ifu_exu_redirect_ack,
    input  exu_ifu_redirect_vld,
    input  exu_ifu_redirect_pc,
    input  exu_ifu_redirect_ertn,
    input  exu_flush,
    input  exu_redirect_busy
  );

endinterface

// File: rtl/cpu7_excp_drain_cnt.sv
// Loadable down-counter that stops at zero and flags it.
module cpu7_excp_drain_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] cnt;

  assign zero = (cnt == '0);

  // Load has priority; decrement saturates at zero so the count never wraps.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - ONE;
    end
  end

endmodule

// File: rtl/cpu7_excp_redirect.sv
// Exception / ertn fetch redirect with post-ack pipeline drain.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | no redirect pending; accepts ale/ertn events
// ST_REQ   | redirect presented to IFU, flush asserted, waiting for ack
// ST_DRAIN | redirect accepted, flush held while the counter runs down
//
// All outputs decode flopped state/target only, so nothing from the
// inputs reaches the outputs combinationally.
module cpu7_excp_redirect
  import cpu7_excp_redirect_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  cpu7_excp_redirect_if.master   bus
);

  // DRAIN is entered with DRAIN_CYCLES-1 so flush lasts DRAIN_CYCLES cycles after the ack cycle.
  localparam logic [CNT_W-1:0] DRAIN_LOAD =
    (DRAIN_CYCLES == 0) ? '0 : CNT_W'(DRAIN_CYCLES - 1);

  redir_state_t     state;
  redir_state_t     state_nxt;
  logic             evt;
  logic             accept;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [GRLEN-1:0] target;
  logic             cause;

  assign evt    = bus.ecl_csr_ale_e | bus.ecl_csr_ertn_e;
  // Events outside IDLE belong to instructions that are being killed.
  assign accept = (state == ST_IDLE) && evt;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and counter-load decode.
  always_comb begin
    state_nxt = ST_IDLE;
    cnt_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        state_nxt = evt ? ST_REQ : ST_IDLE;
      end
      ST_REQ: begin
        if (bus.ifu_exu_redirect_ack) begin
          if (DRAIN_CYCLES == 0) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_DRAIN;
            cnt_load  = 1'b1;
          end
        end else begin
          state_nxt = ST_REQ;
        end
      end
      ST_DRAIN: begin
        state_nxt = cnt_zero ? ST_IDLE : ST_DRAIN;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Target/cause capture on an accepted event; ale wins over ertn.
  // The target is taken from the CSR outputs as they stand in the event cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      target <= '0;
      cause  <= 1'b0;
    end else if (accept) begin
      target <= align_target(bus.ecl_csr_ale_e ? bus.csr_eentry : bus.csr_era);
      cause  <= ~bus.ecl_csr_ale_e;
    end
  end

  assign cnt_dec = (state == ST_DRAIN);

  cpu7_excp_drain_cnt #(
    .CNT_W (CNT_W)
  ) u_drain_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .load     (cnt_load),
    .load_val (DRAIN_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign bus.exu_ifu_redirect_vld  = (state == ST_REQ);
  assign bus.exu_ifu_redirect_pc   = target;
  assign bus.exu_ifu_redirect_ertn = cause;
  assign bus.exu_flush             = (state == ST_REQ) || (state == ST_DRAIN);
  assign bus.exu_redirect_busy     = (state == ST_REQ) || (state == ST_DRAIN);

endmodule

// File: tb/tb_cpu7_excp_redirect.sv
// Directed bench: one instance with a 2-cycle drain, one with no drain.
module tb_cpu7_excp_redirect;

  logic clk = 1'b0;
  logic resetn;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cpu7_excp_redirect_if bus_a ();
  cpu7_excp_redirect_if bus_b ();

  cpu7_excp_redirect #(.DRAIN_CYCLES(2), .CNT_W(4)) dut_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_a)
  );

  cpu7_excp_redirect #(.DRAIN_CYCLES(0), .CNT_W(4)) dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic vld, input logic flush, input logic busy);
    chk({tag, ".vld"},   32'(bus_a.exu_ifu_redirect_vld), 32'(vld));
    chk({tag, ".flush"}, 32'(bus_a.exu_flush),            32'(flush));
    chk({tag, ".busy"},  32'(bus_a.exu_redirect_busy),    32'(busy));
  endtask

  initial begin
    resetn = 1'b0;
    bus_a.ecl_csr_ale_e = 0; bus_a.ecl_csr_ertn_e = 0;
    bus_a.csr_eentry = '0;   bus_a.csr_era = '0;   bus_a.ifu_exu_redirect_ack = 0;
    bus_b.ecl_csr_ale_e = 0; bus_b.ecl_csr_ertn_e = 0;
    bus_b.csr_eentry = '0;   bus_b.csr_era = '0;   bus_b.ifu_exu_redirect_ack = 0;

    // Reset state
    tick(); tick();
    chk_a("rst", 0, 0, 0);
    chk("rst.pc", bus_a.exu_ifu_redirect_pc, 32'h0);
    chk("rst.ertn", 32'(bus_a.exu_ifu_redirect_ertn), 32'h0);
    resetn = 1'b1;
    tick();

    // Exception redirect with delayed ack
    bus_a.ecl_csr_ale_e = 1; bus_a.csr_eentry = 32'h1c000100;
    tick();
    bus_a.ecl_csr_ale_e = 0;
    for (int i = 0; i < 4; i++) begin
      chk_a("exc.req", 1, 1, 1);
      chk("exc.pc", bus_a.exu_ifu_redirect_pc, 32'h1c000100);
      chk("exc.ertn", 32'(bus_a.exu_ifu_redirect_ertn), 32'h0);
      if (i == 3) bus_a.ifu_exu_redirect_ack = 1;
      tick();
    end
    bus_a.ifu_exu_redirect_ack = 0;
    chk_a("exc.drain1", 0, 1, 1);
    tick();
    chk_a("exc.drain2", 0, 1, 1);
    tick();
    chk_a("exc.idle", 0, 0, 0);
    chk("exc.pc_hold", bus_a.exu_ifu_redirect_pc, 32'h1c000100);

    // Ack while idle is ignored
    bus_a.ifu_exu_redirect_ack = 1;
    tick();
    bus_a.ifu_exu_redirect_ack = 0;
    chk_a("ack_idle", 0, 0, 0);

    // Return redirect with masked low bits, ack the following cycle
    bus_a.ecl_csr_ertn_e = 1; bus_a.csr_era = 32'h1c000207;
    tick();
    bus_a.ecl_csr_ertn_e = 0;
    chk_a("ertn.req", 1, 1, 1);
    chk("ertn.pc", bus_a.exu_ifu_redirect_pc, 32'h1c000204);
    chk("ertn.ertn", 32'(bus_a.exu_ifu_redirect_ertn), 32'h1);
    bus_a.ifu_exu_redirect_ack = 1;
    tick();
    bus_a.ifu_exu_redirect_ack = 0;
    chk_a("ertn.drain1", 0, 1, 1);
    tick();
    chk_a("ertn.drain2", 0, 1, 1);
    tick();
    chk_a("ertn.idle", 0, 0, 0);

    // Simultaneous ale and ertn: ale wins
    bus_a.ecl_csr_ale_e = 1; bus_a.ecl_csr_ertn_e = 1;
    bus_a.csr_eentry = 32'hA0; bus_a.csr_era = 32'hB0;
    tick();
    bus_a.ecl_csr_ale_e = 0; bus_a.ecl_csr_ertn_e = 0;
    chk_a("both.req", 1, 1, 1);
    chk("both.pc", bus_a.exu_ifu_redirect_pc, 32'hA0);
    chk("both.ertn", 32'(bus_a.exu_ifu_redirect_ertn), 32'h0);

    // Events during REQ and DRAIN are ignored
    bus_a.ecl_csr_ale_e = 1; bus_a.csr_eentry = 32'h300;
    tick();
    bus_a.ecl_csr_ale_e = 0;
    chk_a("busy_req", 1, 1, 1);
    chk("busy_req.pc", bus_a.exu_ifu_redirect_pc, 32'hA0);
    bus_a.ifu_exu_redirect_ack = 1;
    tick();
    bus_a.ifu_exu_redirect_ack = 0;
    bus_a.ecl_csr_ale_e = 1;
    tick();
    chk_a("busy_drain", 0, 1, 1);
    chk("busy_drain.pc", bus_a.exu_ifu_redirect_pc, 32'hA0);
    tick();
    bus_a.ecl_csr_ale_e = 0;
    chk_a("busy_exit", 0, 0, 0);
    chk("busy_exit.pc", bus_a.exu_ifu_redirect_pc, 32'hA0);
    tick();
    chk_a("no_extra_req", 0, 0, 0);

    // DRAIN_CYCLES=0 instance, ack held high
    bus_b.ecl_csr_ale_e = 1; bus_b.csr_eentry = 32'h1c000044;
    tick();
    bus_b.ecl_csr_ale_e = 0;
    chk("d0.req.vld", 32'(bus_b.exu_ifu_redirect_vld), 32'h1);
    chk("d0.req.pc", bus_b.exu_ifu_redirect_pc, 32'h1c000044);
    bus_b.ifu_exu_redirect_ack = 1;
    tick();
    chk("d0.post.flush", 32'(bus_b.exu_flush), 32'h0);
    chk("d0.post.busy", 32'(bus_b.exu_redirect_busy), 32'h0);
    chk("d0.post.vld", 32'(bus_b.exu_ifu_redirect_vld), 32'h0);
    tick();
    bus_b.ifu_exu_redirect_ack = 0;
    chk("d0.hold.busy", 32'(bus_b.exu_redirect_busy), 32'h0);

    // Asynchronous reset in the middle of REQ
    bus_a.ecl_csr_ale_e = 1; bus_a.csr_eentry = 32'h1c008000;
    tick();
    bus_a.ecl_csr_ale_e = 0;
    chk_a("mid.req", 1, 1, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk_a("mid.rst", 0, 0, 0);
    chk("mid.rst.pc", bus_a.exu_ifu_redirect_pc, 32'h0);
    tick();
    resetn = 1'b1;
    tick();
    chk_a("mid.after", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
